gabor_window_5x5: RTL and testbench

- Streaming 5x5 window generator directly upstream of the 180° Gabor convolution block.
- Accepts one signed pixel per beat in raster order and buffers four full image rows in line buffers.
- Presents the 25 window pixels on pixel1..pixel25 with a valid/ready handshake.
- Emits only fully interior windows (no padding), so a 516x516 frame yields 512x512 windows.

---
 rtl/gabor_pkg.sv | 11 +
 rtl/gabor_line_buffer.sv | 24 ++
 rtl/gabor_window_5x5.sv | 184 ++++++++++++++++++
 tb/tb_gabor_window_5x5.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gabor_pkg.sv
// Shared types and constants for the 5x5 Gabor window generator and its convolution consumer.
package gabor_pkg;

  localparam int unsigned DEFAULT_PIXEL_WIDTH = 9;
  localparam int unsigned KERNEL_SIZE         = 5;
  localparam int unsigned WINDOW_PIXELS       = KERNEL_SIZE * KERNEL_SIZE;

  typedef logic signed [DEFAULT_PIXEL_WIDTH-1:0] pixel_t;
  typedef pixel_t window_t [WINDOW_PIXELS];

endpackage

// File: rtl/gabor_line_buffer.sv
// One image row of pixel storage; read-first single port so a chain of these shifts rows down.
module gabor_line_buffer import gabor_pkg::*; #(
  parameter int unsigned PIXEL_WIDTH = DEFAULT_PIXEL_WIDTH,
  parameter int unsigned DEPTH       = 516
) (
  input  logic                       clk,
  input  logic                       i_wr_en,
  input  logic [$clog2(DEPTH)-1:0]   i_addr,
  input  logic [PIXEL_WIDTH-1:0]     i_wdata,
  output logic [PIXEL_WIDTH-1:0]     o_rdata
);

  logic [PIXEL_WIDTH-1:0] r_mem [DEPTH];

  // Contents are deliberately not reset; each frame refills them before any window is valid.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/gabor_window_5x5.sv
// Streaming 5x5 interior-window generator: four line buffers feed a shifting 5x5 register window.
module gabor_window_5x5 #(
  parameter int unsigned PIXEL_WIDTH = gabor_pkg::DEFAULT_PIXEL_WIDTH,
  parameter int unsigned IMG_WIDTH   = 516,
  parameter int unsigned IMG_HEIGHT  = 516,
  parameter int unsigned KERNEL_SIZE = gabor_pkg::KERNEL_SIZE
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_sof,
  input  logic signed [PIXEL_WIDTH-1:0]  in_pixel,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [PIXEL_WIDTH-1:0]  pixel1,
  output logic signed [PIXEL_WIDTH-1:0]  pixel2,
  output logic signed [PIXEL_WIDTH-1:0]  pixel3,
  output logic signed [PIXEL_WIDTH-1:0]  pixel4,
  output logic signed [PIXEL_WIDTH-1:0]  pixel5,
  output logic signed [PIXEL_WIDTH-1:0]  pixel6,
  output logic signed [PIXEL_WIDTH-1:0]  pixel7,
  output logic signed [PIXEL_WIDTH-1:0]  pixel8,
  output logic signed [PIXEL_WIDTH-1:0]  pixel9,
  output logic signed [PIXEL_WIDTH-1:0]  pixel10,
  output logic signed [PIXEL_WIDTH-1:0]  pixel11,
  output logic signed [PIXEL_WIDTH-1:0]  pixel12,
  output logic signed [PIXEL_WIDTH-1:0]  pixel13,
  output logic signed [PIXEL_WIDTH-1:0]  pixel14,
  output logic signed [PIXEL_WIDTH-1:0]  pixel15,
  output logic signed [PIXEL_WIDTH-1:0]  pixel16,
  output logic signed [PIXEL_WIDTH-1:0]  pixel17,
  output logic signed [PIXEL_WIDTH-1:0]  pixel18,
  output logic signed [PIXEL_WIDTH-1:0]  pixel19,
  output logic signed [PIXEL_WIDTH-1:0]  pixel20,
  output logic signed [PIXEL_WIDTH-1:0]  pixel21,
  output logic signed [PIXEL_WIDTH-1:0]  pixel22,
  output logic signed [PIXEL_WIDTH-1:0]  pixel23,
  output logic signed [PIXEL_WIDTH-1:0]  pixel24,
  output logic signed [PIXEL_WIDTH-1:0]  pixel25,
  output logic [$clog2(IMG_HEIGHT)-1:0]  out_row,
  output logic [$clog2(IMG_WIDTH)-1:0]   out_col,
  output logic                           frame_done
);

  localparam int unsigned CW     = $clog2(IMG_WIDTH);
  localparam int unsigned RW     = $clog2(IMG_HEIGHT);
  localparam int unsigned K      = 5;
  localparam int unsigned NLINES = K - 1;

  if (KERNEL_SIZE != gabor_pkg::KERNEL_SIZE) begin : g_bad_kernel
    $error("gabor_window_5x5 supports KERNEL_SIZE = 5 only");
  end

  logic                          r_out_valid;
  logic                          r_frame_done;
  logic [CW-1:0]                 r_col;
  logic [RW-1:0]                 r_row;
  logic [CW-1:0]                 r_out_col;
  logic [RW-1:0]                 r_out_row;
  logic signed [PIXEL_WIDTH-1:0] r_win [K*K];

  logic                          w_accept;
  logic [CW-1:0]                 w_col;
  logic [RW-1:0]                 w_row;
  logic                          w_col_last;
  logic                          w_row_last;
  logic                          w_win_ok;
  logic [PIXEL_WIDTH-1:0]        w_lb_rd [NLINES];
  logic [PIXEL_WIDTH-1:0]        w_lb_wr [NLINES];
  logic signed [PIXEL_WIDTH-1:0] w_new_col [K];

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // An accepted sof beat is position (0,0) regardless of the running counters.
  assign w_col      = in_sof ? '0 : r_col;
  assign w_row      = in_sof ? '0 : r_row;
  assign w_col_last = (w_col == CW'(IMG_WIDTH - 1));
  assign w_row_last = (w_row == RW'(IMG_HEIGHT - 1));
  assign w_win_ok   = (w_row >= RW'(K - 1)) && (w_col >= CW'(K - 1));

  // Line buffer 0 holds the previous row, buffer 3 the oldest.
  assign w_lb_wr[0] = in_pixel;
  for (genvar g = 1; g < NLINES; g++) begin : g_lb_chain
    assign w_lb_wr[g] = w_lb_rd[g-1];
  end

  for (genvar g = 0; g < NLINES; g++) begin : g_lb
    gabor_line_buffer #(
      .PIXEL_WIDTH (PIXEL_WIDTH),
      .DEPTH       (IMG_WIDTH)
    ) u_line_buffer (
      .clk     (clk),
      .i_wr_en (w_accept),
      .i_addr  (w_col),
      .i_wdata (w_lb_wr[g]),
      .o_rdata (w_lb_rd[g])
    );
    assign w_new_col[g] = w_lb_rd[NLINES-1-g];
  end
  assign w_new_col[K-1] = in_pixel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col        <= '0;
      r_row        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_accept && w_col_last && w_row_last;
      if (w_accept) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : w_row + 1'b1;
        end else begin
          r_col <= w_col + 1'b1;
          r_row <= w_row;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_row   <= '0;
      r_out_col   <= '0;
    end else if (w_accept && w_win_ok) begin
      r_out_valid <= 1'b1;
      r_out_row   <= w_row - RW'(2);
      r_out_col   <= w_col - CW'(2);
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Columns from the previous row linger after a wrap; the col >= 4 gate keeps them unseen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < K*K; i++) begin
        r_win[i] <= '0;
      end
    end else if (w_accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K-1; c++) begin
          r_win[r*K+c] <= r_win[r*K+c+1];
        end
        r_win[r*K+K-1] <= w_new_col[r];
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_row    = r_out_row;
  assign out_col    = r_out_col;
  assign frame_done = r_frame_done;

  assign pixel1  = r_win[0];
  assign pixel2  = r_win[1];
  assign pixel3  = r_win[2];
  assign pixel4  = r_win[3];
  assign pixel5  = r_win[4];
  assign pixel6  = r_win[5];
  assign pixel7  = r_win[6];
  assign pixel8  = r_win[7];
  assign pixel9  = r_win[8];
  assign pixel10 = r_win[9];
  assign pixel11 = r_win[10];
  assign pixel12 = r_win[11];
  assign pixel13 = r_win[12];
  assign pixel14 = r_win[13];
  assign pixel15 = r_win[14];
  assign pixel16 = r_win[15];
  assign pixel17 = r_win[16];
  assign pixel18 = r_win[17];
  assign pixel19 = r_win[18];
  assign pixel20 = r_win[19];
  assign pixel21 = r_win[20];
  assign pixel22 = r_win[21];
  assign pixel23 = r_win[22];
  assign pixel24 = r_win[23];
  assign pixel25 = r_win[24];

endmodule

// File: tb/tb_gabor_window_5x5.sv
// Directed bench for gabor_window_5x5 on an 8x8 frame with a window scoreboard built from a frame model.
module tb_gabor_window_5x5;

  localparam int W = 8;
  localparam int H = 8;

  typedef struct packed {
    logic [24:0][8:0] p;
    logic [2:0]       row;
    logic [2:0]       col;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              in_sof;
  logic signed [8:0] in_pixel;
  logic              out_valid;
  logic              out_ready;
  logic signed [8:0] pix [25];
  logic [2:0]        out_row;
  logic [2:0]        out_col;
  logic              frame_done;

  int   n_cmp = 0;
  int   n_mis = 0;
  int   n_win;
  int   n_fd;
  int   k_step = 0;
  bit   m_ov;
  bit   m_fd;
  int   m_row;
  int   m_col;
  logic [8:0] img [H][W];
  exp_t q [$];

  always #5 clk = ~clk;

  gabor_window_5x5 #(
    .PIXEL_WIDTH (9),
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H),
    .KERNEL_SIZE (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sof     (in_sof),
    .in_pixel   (in_pixel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pixel1     (pix[0]),
    .pixel2     (pix[1]),
    .pixel3     (pix[2]),
    .pixel4     (pix[3]),
    .pixel5     (pix[4]),
    .pixel6     (pix[5]),
    .pixel7     (pix[6]),
    .pixel8     (pix[7]),
    .pixel9     (pix[8]),
    .pixel10    (pix[9]),
    .pixel11    (pix[10]),
    .pixel12    (pix[11]),
    .pixel13    (pix[12]),
    .pixel14    (pix[13]),
    .pixel15    (pix[14]),
    .pixel16    (pix[15]),
    .pixel17    (pix[16]),
    .pixel18    (pix[17]),
    .pixel19    (pix[18]),
    .pixel20    (pix[19]),
    .pixel21    (pix[20]),
    .pixel22    (pix[21]),
    .pixel23    (pix[22]),
    .pixel24    (pix[23]),
    .pixel25    (pix[24]),
    .out_row    (out_row),
    .out_col    (out_col),
    .frame_done (frame_done)
  );

  function automatic logic [31:0] sx(input logic [8:0] v);
    return {{23{v[8]}}, v};
  endfunction

  function automatic logic [8:0] pix_val(input int idx, input int mode);
    int v;
    int tbl [5] = '{-256, -1, 255, 0, -100};
    case (mode)
      0:       v = idx;
      1:       v = tbl[idx % 5];
      default: v = idx + 100;
    endcase
    return v[8:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic model_reset();
    m_ov  = 1'b0;
    m_fd  = 1'b0;
    m_row = 0;
    m_col = 0;
    q.delete();
  endtask

  // One clock: drive, check outputs against the model mid-low-phase, advance the model.
  task automatic step(input bit v, input bit sof, input logic [8:0] px, input bit ordy,
                      output bit acc);
    int   r;
    int   c;
    bit   ov_n;
    bit   fd_n;
    exp_t e;
    in_valid  = v;
    in_sof    = sof;
    in_pixel  = px;
    out_ready = ordy;
    #1;
    check("in_ready", 32'(in_ready), 32'(!m_ov || ordy));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("frame_done", 32'(frame_done), 32'(m_fd));
    if (frame_done === 1'b1) n_fd++;
    if (out_valid === 1'b1) begin
      check("window_expected", 32'(q.size() > 0), 1);
      if (q.size() > 0) begin
        for (int k = 0; k < 25; k++) begin
          check($sformatf("pixel%0d", k + 1), sx(pix[k]), sx(q[0].p[k]));
        end
        check("out_row", 32'(out_row), 32'(q[0].row));
        check("out_col", 32'(out_col), 32'(q[0].col));
        if (ordy) begin
          void'(q.pop_front());
          n_win++;
        end
      end
    end
    acc  = v && (!m_ov || ordy);
    fd_n = 1'b0;
    ov_n = ordy ? 1'b0 : m_ov;
    if (acc) begin
      r = sof ? 0 : m_row;
      c = sof ? 0 : m_col;
      img[r][c] = px;
      if (r == H - 1 && c == W - 1) fd_n = 1'b1;
      if (r >= 4 && c >= 4) begin
        for (int kr = 0; kr < 5; kr++) begin
          for (int kc = 0; kc < 5; kc++) begin
            e.p[kr*5+kc] = img[r-4+kr][c-4+kc];
          end
        end
        e.row = 3'(r - 2);
        e.col = 3'(c - 2);
        q.push_back(e);
        ov_n = 1'b1;
      end
      if (c == W - 1) begin
        m_col = 0;
        m_row = (r == H - 1) ? 0 : r + 1;
      end else begin
        m_col = c + 1;
        m_row = r;
      end
    end
    @(negedge clk);
    m_ov = ov_n;
    m_fd = fd_n;
  endtask

  task automatic drive_beats(input int first, input int count, input int mode, input bit toggle);
    int idx;
    int tries;
    bit acc;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    idx   = first;
    tries = 0;
    while (idx < first + count && tries < count * 6 + 20) begin
      step(1'b1, idx == 0, pix_val(idx, mode), toggle ? pat[k_step % 4] : 1'b1, acc);
      k_step++;
      tries++;
      if (acc) idx++;
    end
    check("beats_accepted", idx, first + count);
  endtask

  task automatic drain(input int n);
    bit acc;
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 9'd0, 1'b1, acc);
    end
  endtask

  task automatic full_frame(input string tag, input int mode, input bit toggle);
    n_win = 0;
    n_fd  = 0;
    drive_beats(0, W * H, mode, toggle);
    drain(4);
    check({tag, "_windows"}, n_win, 16);
    check({tag, "_frame_done"}, n_fd, 1);
    check({tag, "_queue_empty"}, q.size(), 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_pixel  = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_pixel1", sx(pix[0]), 0);
    check("rst_pixel25", sx(pix[24]), 0);
    check("rst_out_row", 32'(out_row), 0);
    check("rst_out_col", 32'(out_col), 0);

    // Ramp frame, free-flowing output.
    full_frame("s1", 0, 1'b0);
    // Same frame with back-pressure.
    full_frame("s2", 0, 1'b1);
    // Extreme signed values.
    full_frame("s4", 1, 1'b1);

    // Abort at (5,3) with a new sof; only the restarted frame completes.
    n_win = 0;
    n_fd  = 0;
    drive_beats(0, 5 * W + 3, 0, 1'b0);
    drive_beats(0, W * H, 2, 1'b0);
    drain(4);
    check("s5_windows", n_win, 20);
    check("s5_frame_done", n_fd, 1);
    check("s5_queue_empty", q.size(), 0);

    // Asynchronous reset while a window is presented.
    drive_beats(0, 37, 0, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("s6_pre_valid", 32'(out_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    check("s6_out_valid", 32'(out_valid), 0);
    check("s6_frame_done", 32'(frame_done), 0);
    check("s6_pixel1", sx(pix[0]), 0);
    check("s6_pixel13", sx(pix[12]), 0);
    check("s6_pixel25", sx(pix[24]), 0);
    check("s6_out_row", 32'(out_row), 0);
    check("s6_out_col", 32'(out_col), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    full_frame("s6", 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
